// File: rtl/jtpopeye_rom_pkg.sv
// ---------------------------------------------------------------------------
// jtpopeye_rom_pkg : shared types and constants for the Popeye ROM arbiter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package jtpopeye_rom_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [21:0] C_OFF0 = 22'h000000;
  localparam logic [21:0] C_OFF1 = 22'h004000;
  localparam logic [21:0] C_OFF2 = 22'h006000;

  function automatic logic [1:0] next_slot(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/jtpopeye_rom_slot.sv
// ---------------------------------------------------------------------------
// jtpopeye_rom_slot : one-entry 32-bit line cache for a single ROM requester
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jtpopeye_rom_slot #(
  parameter int AW      = 15,
  parameter int TAG_LSB = 2,
  parameter int DW      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inv,
  input  logic [AW-1:0]         addr,
  input  logic                  cs,
  output logic                  ok,
  output logic [DW-1:0]         dout,
  output logic [AW-TAG_LSB-1:0] tag,
  input  logic                  fill_en,
  input  logic [AW-TAG_LSB-1:0] fill_tag,
  input  logic [31:0]           fill_data
);

  localparam int TW = AW - TAG_LSB;

  logic [TW-1:0] tag_q,   tag_d;
  logic          valid_q, valid_d;
  logic [31:0]   line_q,  line_d;

  assign tag = addr[AW-1:TAG_LSB];
  assign ok  = cs & valid_q & ~inv & (tag == tag_q);

  always_comb begin
    tag_d   = tag_q;
    valid_d = valid_q;
    line_d  = line_q;
    // A fill landing while a download runs is dropped on purpose
    if (inv) begin
      valid_d = 1'b0;
    end else if (fill_en) begin
      tag_d   = fill_tag;
      valid_d = 1'b1;
      line_d  = fill_data;
    end
    if (clr) begin
      tag_d   = '0;
      valid_d = 1'b0;
      line_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q   <= '0;
      valid_q <= 1'b0;
      line_q  <= '0;
    end else begin
      tag_q   <= tag_d;
      valid_q <= valid_d;
      line_q  <= line_d;
    end
  end

  generate
    if (DW == 32) begin : g_full
      logic unused_sel;
      assign unused_sel = ^addr[TAG_LSB-1:0];
      assign dout       = line_q;
    end else begin : g_part
      localparam int SW = $clog2(32 / DW);
      localparam int BW = $clog2(DW);
      logic [SW-1:0] sel;
      assign sel  = addr[SW-1:0];
      assign dout = line_q[{sel, {BW{1'b0}}} +: DW];
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/jtpopeye_rom_arbiter.sv
// ---------------------------------------------------------------------------
// jtpopeye_rom_arbiter : three cached ROM requesters sharing one SDRAM port
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jtpopeye_rom_arbiter
  import jtpopeye_rom_pkg::*;
#(
  parameter int          AW0  = 15,
  parameter int          AW1  = 13,
  parameter int          AW2  = 14,
  parameter logic [21:0] OFF0 = C_OFF0,
  parameter logic [21:0] OFF1 = C_OFF1,
  parameter logic [21:0] OFF2 = C_OFF2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           loop_rst,
  input  logic           downloading,
  input  logic [AW0-1:0] slot0_addr,
  input  logic           slot0_cs,
  output logic           slot0_ok,
  output logic [7:0]     slot0_dout,
  input  logic [AW1-1:0] slot1_addr,
  input  logic           slot1_cs,
  output logic           slot1_ok,
  output logic [15:0]    slot1_dout,
  input  logic [AW2-1:0] slot2_addr,
  input  logic           slot2_cs,
  output logic           slot2_ok,
  output logic [31:0]    slot2_dout,
  output logic [21:0]    sdram_addr,
  output logic           sdram_req,
  input  logic           sdram_ack,
  input  logic [31:0]    data_read,
  input  logic           data_rdy,
  output logic           refresh_en
);

  localparam int TW0 = AW0 - 2;
  localparam int TW1 = AW1 - 1;
  localparam int TW2 = AW2 - 1;
  localparam int TWA = (TW0 > TW1) ? TW0 : TW1;
  localparam int TWM = (TWA > TW2) ? TWA : TW2;

  state_t         state_q, state_d;
  logic [1:0]     gnt_q,   gnt_d;
  logic [1:0]     last_q,  last_d;
  logic [21:0]    addr_q,  addr_d;
  logic [TWM-1:0] gtag_q,  gtag_d;

  logic [TW0-1:0] tag0;
  logic [TW1-1:0] tag1;
  logic [TW2-1:0] tag2;
  logic [21:0]    la0, la1, la2;
  logic [2:0]     miss;
  logic           fill;
  logic [1:0]     cand;
  logic           found;

  jtpopeye_rom_slot #(.AW(AW0), .TAG_LSB(2), .DW(8)) u_slot0 (
    .clk(clk), .rst(rst), .clr(loop_rst), .inv(downloading),
    .addr(slot0_addr), .cs(slot0_cs), .ok(slot0_ok), .dout(slot0_dout), .tag(tag0),
    .fill_en(fill && gnt_q == 2'd0), .fill_tag(gtag_q[TW0-1:0]), .fill_data(data_read)
  );

  jtpopeye_rom_slot #(.AW(AW1), .TAG_LSB(1), .DW(16)) u_slot1 (
    .clk(clk), .rst(rst), .clr(loop_rst), .inv(downloading),
    .addr(slot1_addr), .cs(slot1_cs), .ok(slot1_ok), .dout(slot1_dout), .tag(tag1),
    .fill_en(fill && gnt_q == 2'd1), .fill_tag(gtag_q[TW1-1:0]), .fill_data(data_read)
  );

  jtpopeye_rom_slot #(.AW(AW2), .TAG_LSB(1), .DW(32)) u_slot2 (
    .clk(clk), .rst(rst), .clr(loop_rst), .inv(downloading),
    .addr(slot2_addr), .cs(slot2_cs), .ok(slot2_ok), .dout(slot2_dout), .tag(tag2),
    .fill_en(fill && gnt_q == 2'd2), .fill_tag(gtag_q[TW2-1:0]), .fill_data(data_read)
  );

  assign la0  = OFF0 + 22'({tag0, 1'b0});
  assign la1  = OFF1 + 22'({tag1, 1'b0});
  assign la2  = OFF2 + 22'({tag2, 1'b0});
  assign miss = {slot2_cs & ~slot2_ok, slot1_cs & ~slot1_ok, slot0_cs & ~slot0_ok};

  assign sdram_addr = addr_q;
  assign sdram_req  = (state_q == ST_REQ);
  assign refresh_en = (state_q == ST_IDLE) & ~(|miss) & ~downloading;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    addr_d  = addr_q;
    gtag_d  = gtag_q;
    fill    = 1'b0;
    cand    = next_slot(last_q);
    found   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|miss && !downloading) begin
          // Search starts just after the last winner
          for (int k = 0; k < 3; k++) begin
            if (!found && miss[cand]) begin
              found = 1'b1;
              gnt_d = cand;
            end
            cand = next_slot(cand);
          end
          last_d  = gnt_d;
          state_d = ST_REQ;
          case (gnt_d)
            2'd0:    begin addr_d = la0; gtag_d = TWM'(tag0); end
            2'd1:    begin addr_d = la1; gtag_d = TWM'(tag1); end
            default: begin addr_d = la2; gtag_d = TWM'(tag2); end
          endcase
        end
      end
      ST_REQ: begin
        if (sdram_ack) begin
          if (data_rdy) begin
            fill    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (data_rdy) begin
          fill    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (loop_rst) begin
      state_d = ST_IDLE;
      gnt_d   = 2'd0;
      last_d  = 2'd2;
      addr_d  = '0;
      gtag_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'd0;
      last_q  <= 2'd2;
      addr_q  <= '0;
      gtag_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      gtag_q  <= gtag_d;
    end
  end

endmodule

`default_nettype wire

// File: doc/jtpopeye_rom_arbiter.md
Name: jtpopeye_rom_arbiter

Overview:
- Shares the single jtframe SDRAM read port (sdram_addr/req/ack, data_read/data_rdy) between three game ROM requesters: main CPU, background/char, sprite.
- Each requester gets a one-entry 32-bit line cache, so repeated fetches inside the same line never reach SDRAM.
- Drives refresh_en so SDRAM refresh only happens when no miss is pending.
- Sits inside jtpopeye_game, between the video/CPU ROM consumers and the frame SDRAM controller.

Parameters:
- AW0, 15, slot 0 (main CPU) byte address width; 8-bit data.
- AW1, 13, slot 1 (char) 16-bit word address width.
- AW2, 14, slot 2 (sprite) 16-bit word address width.
- OFF0, 22'h00000, slot 0 SDRAM word offset.
- OFF1, 22'h04000, slot 1 SDRAM word offset.
- OFF2, 22'h06000, slot 2 SDRAM word offset.

Ports:
- clk  in  1  system clock (40 MHz)
- rst  in  1  asynchronous, active-high reset
- loop_rst  in  1  frame loop reset; synchronous clear, same effect as rst
- downloading  in  1  ROM download in progress
- slot0_addr  in  AW0  CPU byte address
- slot0_cs  in  1  CPU request
- slot0_ok  out  1  slot0_dout valid for current addr
- slot0_dout  out  8  CPU byte
- slot1_addr  in  AW1  char word address
- slot1_cs  in  1  char request
- slot1_ok  out  1  slot1_dout valid
- slot1_dout  out  16  char word
- slot2_addr  in  AW2  sprite word address
- slot2_cs  in  1  sprite request
- slot2_ok  out  1  slot2_dout valid
- slot2_dout  out  32  sprite line, two words
- sdram_addr  out  22  SDRAM 16-bit word address
- sdram_req  out  1  read request
- sdram_ack  in  1  request accepted
- data_read  in  32  returned data, 2 words
- data_rdy  in  1  data_read valid
- refresh_en  out  1  SDRAM refresh permitted

Behaviour:
- Line = 32 bits = 2 SDRAM words.
- Tags:
  - slot0 tag = addr[AW0-1:2]
  - slot1 tag = addr[AW1-1:1]
  - slot2 tag = addr[AW2-1:1]
- SDRAM line address = OFFn + {tag,1'b0}. Slot 2 uses the same line rule; sprite fetches must be word-pair aligned.
- Hit: slotN_ok = cs & valid & (addr tag == stored tag). Combinational from registered tag/valid. Zero added latency.
- Data selection:
  - slot0_dout = byte addr[1:0] of the line (00 → [7:0] … 11 → [31:24]).
  - slot1_dout = addr[0] ? [31:16] : [15:0].
  - slot2_dout = full line.
- Miss pending: cs & !hit.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: if any miss is pending and !downloading, grant one slot round-robin, starting after the last granted slot (pointer resets to slot 2, so slot 0 wins first). Latch the grant and its line address. Go to REQ.
  - REQ: sdram_req=1 and sdram_addr held. On sdram_ack, drop sdram_req and go to WAIT.
  - WAIT: on data_rdy, write data_read to the granted slot's line, set its tag from the latched address and valid=1. Go to IDLE.
- If a requester changes addr during REQ/WAIT, the fill still completes with the latched tag. The new address then misses and re-requests.
- If data_rdy and sdram_ack arrive in the same cycle while in REQ: treat as ack then fill. Go straight to IDLE.
- Miss-to-ok latency: 1 (IDLE→REQ) + ack wait + data wait + 1 (fill register).
- refresh_en = (state==IDLE) & no pending miss & !downloading.
- downloading=1:
  - Clears all valid bits and holds ok=0 (every cs misses).
  - In IDLE: no new grant.
  - In REQ/WAIT: the current transaction completes, but data is discarded (valid stays 0).
- rst or loop_rst:
  - state=IDLE, sdram_req=0, sdram_addr=0, all valid=0, all tags=0, all line data=0, RR pointer=2.
  - Outputs: ok=0, dout=0, refresh_en=1 once rst releases and no cs is active.
- Fairness: worst case, a miss waits for two other fills.

Decomposition:
- Package jtpopeye_rom_pkg holds the state encoding (IDLE/REQ/WAIT) and the default OFFn constants.
- One sub-module, jtpopeye_rom_slot, instantiated three times, parameterised by address width, tag split and output width. It holds the tag, valid and line registers, hit compare, data select, and fill port.
- The arbiter FSM and round-robin logic stay in the top.

Test Plan:
- Slot0 cs, addr 15'h0005, cold → sdram_addr=22'h000002, one req; on data_rdy with 32'hDDCCBBAA, ok=1 and dout=8'hBB. Then addr 15'h0007 → hit with no req, dout=8'hDD.
- Slot0, 1 and 2 all miss in the same cycle → grants in order 0, 1, 2. Slot2 addr 14'h0010 gives sdram_addr=22'h006010.
- Slot1 addr 13'h0003, fill 32'h12345678 → dout=16'h1234. Addr 13'h0002 → hit, dout=16'h5678.
- Assert rst in WAIT → sdram_req=0 and all ok=0 at once. A late data_rdy is ignored; the next cs re-requests.
- Pulse downloading after lines are valid → all ok=0, refresh_en=0. After downloading falls, the first cs misses and requests.
- No cs active → refresh_en=1. Slot1 miss → refresh_en=0 the same cycle, and stays 0 until the fill completes.
